barrett_param_gen_32b: RTL and testbench
========================================

BARRETT_PARAM_GEN_32B -- requirements
Module: barrett_param_gen_32b

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the modulus width.
REQ-003 Parameter K_W, default 6, SHALL set the width of oK.
REQ-004 Parameter U_W, default 64 (2*DATA_W), SHALL set the width of oU.
REQ-005 iClk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-006 iRst  input  1  SHALL be the asynchronous active-high reset.
REQ-007 iStart  input  1  SHALL request a computation; sampled only in IDLE.
REQ-008 iClr  input  1  SHALL be a synchronous abort.
REQ-009 iMod  input  DATA_W  SHALL be the modulus M, captured when start is accepted.
REQ-010 oBusy  output  1  SHALL be high in every state except IDLE.
REQ-011 oDone  output  1  SHALL be a one-cycle completion pulse.
REQ-012 oErr  output  1  SHALL be high with oDone when M < 2.
REQ-013 oK  output  K_W  SHALL be k, the bit length of M (2^(k-1) <= M < 2^k), as used by the Barrett multiplier iK port.
REQ-014 oU  output  U_W  SHALL be U = floor(2^(2k) / M), as used by the Barrett multiplier iU port.

Function
REQ-015 States: IDLE, CALCK, DIV, DONE, ERR.
REQ-016 IDLE to CALCK when iStart=1 and iMod >= 2; M is latched into an internal register.
REQ-017 IDLE to ERR when iStart=1 and iMod < 2; ERR lasts 1 cycle (oDone=1, oErr=1, oK=0, oU=0), then IDLE.
REQ-018 CALCK lasts 1 cycle: k = DATA_W - leading_zero_count(M); iteration counter loaded with 2k+1.
REQ-019 DIV: restoring division of dividend 2^(2k) by M, one quotient bit per cycle, MSB first, for exactly 2k+1 cycles.
REQ-020 Remainder register SHALL be DATA_W+1 bits; quotient register U_W bits, shifted left each DIV cycle.
REQ-021 DONE lasts 1 cycle: oDone=1, oErr=0; oK and oU are updated at entry to DONE; then IDLE.
REQ-022 Latency SHALL be 2k+3 rising edges from the start-accepting edge to the edge on which oDone rises (k=13: 29; k=32: 67).
REQ-023 oK, oU and oErr SHALL hold their last values until the next DONE or ERR.
REQ-024 iStart while oBusy=1 SHALL be ignored, with no queuing.
REQ-025 iMod changes after acceptance SHALL have no effect on the computation in progress.
REQ-026 iClr=1 in any state SHALL force IDLE on the next edge: no oDone pulse, oK/oU/oErr unchanged.
REQ-027 iClr has priority over iStart on the same cycle.
REQ-028 Largest result: M = 2^31 gives k=32, U = 2^33, which SHALL fit in U_W without truncation.

Reset
REQ-029 While iRst=1, the state SHALL be IDLE and all internal registers SHALL be 0, independent of the clock.
REQ-030 After reset: oBusy=0, oDone=0, oErr=0, oK=0, oU=0.
REQ-031 Reset mid-DIV SHALL discard the computation and emit no oDone.

Structure
REQ-032 Package barrett_pkg SHALL hold DATA_W, K_W, U_W and the state enum type.
REQ-033 Sub-module lzc32 (combinational 32-bit leading-zero counter, 6-bit output, returns 32 for input 0) SHALL be instantiated once.

Verification
REQ-034 iMod=7681, pulse iStart -> oDone after 29 edges, oK=13, oU=8736, oErr=0.
REQ-035 iMod=32'hFFFFFFFF -> oDone after 67 edges, oK=32, oU=64'h1_0000_0001.
REQ-036 iMod=32'h80000000 -> oK=32, oU=64'h2_0000_0000; iMod=2 -> oK=2, oU=8.
REQ-037 iMod=0 or 1 -> oDone and oErr high 1 edge after start; oK=0, oU=0.
REQ-038 Start 7681, then at DIV cycle 5 pulse iStart with iMod=3 and assert iRst at cycle 10 -> second start ignored; after reset all outputs are 0 and no oDone is seen; a following start with iMod=3 -> oK=2, oU=5.
REQ-039 1000 random iMod values with iClr pulses injected mid-DIV -> each completed result matches a golden model (k from bit length, U = 2^(2k) div M); aborted runs produce no oDone and leave the prior oK/oU unchanged.

Source files
------------

// File: rtl/barrett_pkg.sv
// rtl/barrett_pkg.sv - shared widths and state type for the Barrett parameter generator
package barrett_pkg;

    localparam int DATA_W = 32;
    localparam int K_W    = 6;
    localparam int U_W    = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALCK = 3'd1,
        ST_DIV   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter (32 for a zero input)
module lzc32 (
    input  logic [31:0] data_i,
    output logic [5:0]  count_o
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        count_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data_i[i]) begin
                count_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/barrett_param_gen_32b.sv
// rtl/barrett_param_gen_32b.sv - computes k = bitlen(M) and U = floor(2^(2k)/M) for a Barrett multiplier
module barrett_param_gen_32b
    import barrett_pkg::*;
#(
    parameter int DATA_W = barrett_pkg::DATA_W,
    parameter int K_W    = barrett_pkg::K_W,
    parameter int U_W    = barrett_pkg::U_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iClr,
    input  logic [DATA_W-1:0] iMod,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic [K_W-1:0]    oK,
    output logic [U_W-1:0]    oU
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [K_W:0]        cnt_q, cnt_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [U_W-1:0]      quo_q, quo_d;
    logic [K_W-1:0]      ok_q, ok_d;
    logic [U_W-1:0]      ou_q, ou_d;
    logic                err_q, err_d;

    logic [5:0]          lzc_cnt;
    logic [K_W:0]        k_wide;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_sub;
    logic                rem_ge;
    logic [U_W-1:0]      quo_next;

    lzc32 u_lzc (
        .data_i  (m_q),
        .count_o (lzc_cnt)
    );

    // Bit length of the latched modulus, and one restoring-division step.
    // The dividend 2^(2k) has only its top bit set, which enters on the first DIV cycle.
    always_comb begin
        k_wide    = (K_W+1)'(DATA_W) - (K_W+1)'(lzc_cnt);
        rem_shift = {rem_q[DATA_W-1:0], (cnt_q == {k_q, 1'b1})};
        rem_ge    = (rem_shift >= {1'b0, m_q});
        rem_sub   = rem_shift - {1'b0, m_q};
        quo_next  = {quo_q[U_W-2:0], rem_ge};
    end

    // Next-state and datapath updates; results are written only on entry to DONE or ERR
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        ok_d    = ok_q;
        ou_d    = ou_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (iMod < DATA_W'(2)) begin
                        state_d = ST_ERR;
                        ok_d    = '0;
                        ou_d    = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_CALCK;
                        m_d     = iMod;
                    end
                end
            end
            ST_CALCK: begin
                k_d     = k_wide[K_W-1:0];
                cnt_d   = {k_wide[K_W-1:0], 1'b1};
                rem_d   = '0;
                quo_d   = '0;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                rem_d = rem_ge ? rem_sub : rem_shift;
                quo_d = quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == (K_W+1)'(1)) begin
                    state_d = ST_DONE;
                    ok_d    = k_q;
                    ou_d    = quo_next;
                    err_d   = 1'b0;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over everything, including a same-cycle start, and keeps the last results
        if (iClr) begin
            state_d = ST_IDLE;
            ok_d    = ok_q;
            ou_d    = ou_q;
            err_d   = err_q;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            ok_q    <= '0;
            ou_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            ok_q    <= ok_d;
            ou_q    <= ou_d;
            err_q   <= err_d;
        end
    end

    assign oBusy = (state_q != ST_IDLE);
    assign oDone = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign oErr  = err_q;
    assign oK    = ok_q;
    assign oU    = ou_q;

endmodule

// File: tb/tb_barrett_param_gen_32b.sv
// tb/tb_barrett_param_gen_32b.sv - self-checking bench for barrett_param_gen_32b
module tb_barrett_param_gen_32b;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iClr;
    logic [31:0] iMod;
    logic        oBusy;
    logic        oDone;
    logic        oErr;
    logic [5:0]  oK;
    logic [63:0] oU;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_k;
    logic [63:0] exp_u;
    logic        exp_err;

    barrett_param_gen_32b dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iClr   (iClr),
        .iMod   (iMod),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oErr   (oErr),
        .oK     (oK),
        .oU     (oU)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int bitlen(input logic [31:0] m);
        int k = 0;
        while (k < 32 && {32'd0, m} >= (64'd1 << k)) k++;
        return k;
    endfunction

    function automatic logic [127:0] u_of(input logic [31:0] m);
        return (128'd1 << (2 * bitlen(m))) / {96'd0, m};
    endfunction

    // Pulse start with modulus m; lat counts edges with the accepting edge as 1.
    // A nonzero clr_at raises iClr after that edge; the run then stops one edge later.
    task automatic start_and_wait(input logic [31:0] m, input int clr_at,
                                  output int lat, output bit done_seen);
        lat = 0;
        done_seen = 1'b0;
        @(negedge iClk);
        iMod = m;
        iStart = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge iClk);
            @(negedge iClk);
            iStart = 1'b0;
            iClr = 1'b0;
            iMod = $urandom;
            if (oDone) begin
                done_seen = 1'b1;
                lat = e;
                break;
            end
            if (clr_at > 0 && e > clr_at) break;
            if (e == clr_at) iClr = 1'b1;
        end
        iClr = 1'b0;
        if (done_seen) @(negedge iClk);
    endtask

    task automatic run_check(input logic [31:0] m, input int clr_at);
        int lat;
        bit seen;
        start_and_wait(m, clr_at, lat, seen);
        if (clr_at > 0) begin
            chk("abort_no_done", {127'd0, seen}, 128'd0);
            chk("abort_idle", {127'd0, oBusy}, 128'd0);
            chk("abort_k_held", {122'd0, oK}, {122'd0, exp_k});
            chk("abort_u_held", {64'd0, oU}, {64'd0, exp_u});
            chk("abort_err_held", {127'd0, oErr}, {127'd0, exp_err});
        end else begin
            if (m < 2) begin
                exp_k = 0;
                exp_u = 0;
                exp_err = 1'b1;
                chk("latency", lat, 1);
            end else begin
                exp_k = 6'(bitlen(m));
                exp_u = 64'(u_of(m));
                exp_err = 1'b0;
                chk("latency", lat, 2 * bitlen(m) + 3);
            end
            chk("done_seen", {127'd0, seen}, 128'd1);
            chk("k", {122'd0, oK}, {122'd0, exp_k});
            chk("u", {64'd0, oU}, {64'd0, exp_u});
            chk("err", {127'd0, oErr}, {127'd0, exp_err});
        end
    endtask

    initial begin
        bit         saw_done;
        logic [31:0] m;
        int         clr_at;

        iRst = 1'b1;
        iStart = 1'b0;
        iClr = 1'b0;
        iMod = '0;
        exp_k = 0;
        exp_u = 0;
        exp_err = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        chk("rst_busy", {127'd0, oBusy}, 128'd0);
        chk("rst_done", {127'd0, oDone}, 128'd0);
        chk("rst_err", {127'd0, oErr}, 128'd0);
        chk("rst_k", {122'd0, oK}, 128'd0);
        chk("rst_u", {64'd0, oU}, 128'd0);
        iRst = 1'b0;

        // directed reference points
        run_check(32'd7681, 0);
        chk("k_7681", {122'd0, oK}, 128'd13);
        chk("u_7681", {64'd0, oU}, 128'd8736);
        run_check(32'hFFFF_FFFF, 0);
        chk("u_ffffffff", {64'd0, oU}, 128'h1_0000_0001);
        run_check(32'd0, 0);
        run_check(32'h8000_0000, 0);
        chk("u_2p31", {64'd0, oU}, 128'h2_0000_0000);
        run_check(32'd1, 0);
        run_check(32'd2, 0);
        chk("u_2", {64'd0, oU}, 128'd8);

        // clear beats start in the same cycle
        @(negedge iClk);
        iMod = 32'd5;
        iStart = 1'b1;
        iClr = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        iClr = 1'b0;
        chk("clr_over_start", {127'd0, oBusy}, 128'd0);

        // second start during DIV ignored, then reset mid-DIV
        @(negedge iClk);
        iMod = 32'd7681;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (5) @(negedge iClk);
        iStart = 1'b1;
        iMod = 32'd3;
        @(negedge iClk);
        iStart = 1'b0;
        chk("ignored_start_busy", {127'd0, oBusy}, 128'd1);
        repeat (3) @(negedge iClk);
        iRst = 1'b1;
        #1;
        exp_k = 0;
        exp_u = 0;
        exp_err = 1'b0;
        chk("midrst_busy", {127'd0, oBusy}, 128'd0);
        chk("midrst_k", {122'd0, oK}, 128'd0);
        chk("midrst_u", {64'd0, oU}, 128'd0);
        chk("midrst_err", {127'd0, oErr}, 128'd0);
        @(negedge iClk);
        iRst = 1'b0;
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge iClk);
            if (oDone) saw_done = 1'b1;
        end
        chk("midrst_no_done", {127'd0, saw_done}, 128'd0);
        run_check(32'd3, 0);
        chk("u_3", {64'd0, oU}, 128'd5);

        // randomized moduli with occasional mid-DIV aborts
        for (int n = 0; n < 1000; n++) begin
            m = $urandom >> $urandom_range(0, 31);
            clr_at = 0;
            if (m >= 2 && $urandom_range(0, 3) == 0)
                clr_at = $urandom_range(3, 2 * bitlen(m) + 2);
            run_check(m, clr_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
